// File: rtl/reg_bank_arb_pkg.sv
// Shared types for the register-bank arbiter: FSM state encoding and
// requester identifiers.
package reg_bank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin arbiter in front of the register bank, with a
// bounded-wait timeout so a missing slave ack cannot hang a requester.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int REG_W     = 8,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              m0_req,
  input  logic              m0_wr_rdn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [REG_W-1:0]  m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [REG_W-1:0]  m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr_rdn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [REG_W-1:0]  m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [REG_W-1:0]  m1_rdata,
  output logic              s_sel,
  output logic              s_wr_rdn,
  output logic [ADDR_W-1:0] s_addr,
  output logic [REG_W-1:0]  s_wdata,
  output logic              s_we,
  input  logic [REG_W-1:0]  s_rdata,
  input  logic              s_ack,
  input  logic              s_err,
  output logic              busy,
  output logic              gnt_id
);

  arb_state_e           state, state_nxt;
  logic                 last_srv;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 grant;
  logic                 capture;
  logic                 timeout;
  logic                 win_id;
  logic [REG_W-1:0]     cap_rdata;
  logic                 cap_err;

  // Contention goes to whoever was not served last; a sole requester always wins.
  always_comb begin
    win_id = REQ_SPI;
    if (m0_req && m1_req) win_id = ~last_srv;
    else if (m1_req)      win_id = REQ_DBG;
  end

  // Ack takes priority over expiry, so timeout is only flagged without s_ack.
  assign timeout   = (state == WAIT) && !s_ack && (wait_cnt == '1);
  assign cap_rdata = (timeout || s_wr_rdn) ? '0 : s_rdata;
  assign cap_err   = timeout ? 1'b1 : s_err;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (ena && (m0_req || m1_req)) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture   = s_ack;
        state_nxt = s_ack ? RESP : WAIT;
      end
      WAIT: begin
        if (s_ack || timeout) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      gnt_id   <= REQ_SPI;
      last_srv <= REQ_DBG;
      s_wr_rdn <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      wait_cnt <= '0;
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else begin
      if (grant) begin
        gnt_id   <= win_id;
        s_wr_rdn <= win_id ? m1_wr_rdn : m0_wr_rdn;
        s_addr   <= win_id ? m1_addr   : m0_addr;
        s_wdata  <= win_id ? m1_wdata  : m0_wdata;
      end
      if (state == ISSUE)                wait_cnt <= '0;
      else if (state == WAIT && !s_ack)  wait_cnt <= wait_cnt + 1'b1;
      // Response lands directly in the owner's registers and holds until its next RESP.
      if (capture) begin
        if (gnt_id == REQ_DBG) begin
          m1_rdata <= cap_rdata;
          m1_err   <= cap_err;
        end else begin
          m0_rdata <= cap_rdata;
          m0_err   <= cap_err;
        end
      end
      if (state == RESP) last_srv <= gnt_id;
    end
  end

  assign s_sel  = (state == ISSUE) || (state == WAIT);
  assign s_we   = s_sel & s_wr_rdn;
  assign busy   = (state != IDLE);
  assign m0_ack = (state == RESP) && (gnt_id == REQ_SPI);
  assign m1_ack = (state == RESP) && (gnt_id == REQ_DBG);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios plus randomized
// traffic against a transaction-level round-robin/timeout model.
module tb_reg_bank_arbiter;

  localparam int REG_W     = 8;
  localparam int ADDR_W    = 8;
  localparam int TIMEOUT_W = 4;
  localparam int TMO       = 1 << TIMEOUT_W;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              ena = 1'b0;
  logic              m0_req = 1'b0, m0_wr_rdn = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [REG_W-1:0]  m0_wdata = '0;
  logic              m0_ack, m0_err;
  logic [REG_W-1:0]  m0_rdata;
  logic              m1_req = 1'b0, m1_wr_rdn = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [REG_W-1:0]  m1_wdata = '0;
  logic              m1_ack, m1_err;
  logic [REG_W-1:0]  m1_rdata;
  logic              s_sel, s_wr_rdn, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [REG_W-1:0]  s_wdata;
  logic [REG_W-1:0]  s_rdata = '0;
  logic              s_ack = 1'b0, s_err = 1'b0;
  logic              busy, gnt_id;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .m0_req(m0_req), .m0_wr_rdn(m0_wr_rdn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr_rdn(m1_wr_rdn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_sel(s_sel), .s_wr_rdn(s_wr_rdn), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_rdata(s_rdata), .s_ack(s_ack), .s_err(s_err),
    .busy(busy), .gnt_id(gnt_id)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: who was served last, and each requester's held response.
  logic             model_last;
  logic [REG_W-1:0] exp_rd [2];
  logic             exp_er [2];

  task automatic apply_reset();
    rstb = 1'b0; ena = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
  endtask

  // One arbitrated transaction from the current request state; slave acks after
  // 'lat' cycles of s_sel (lat >= TMO means no ack at all).
  task automatic do_txn(input int lat, input bit drop_ena, input int force_err, input int fix_rd);
    logic w, wr, ee, eerr, ack_w, ack_o;
    logic [ADDR_W-1:0] ad;
    logic [REG_W-1:0]  wd, rv, er;
    int nsel;
    ena = 1'b1;
    w  = (m0_req && m1_req) ? ~model_last : m1_req;
    wr = w ? m1_wr_rdn : m0_wr_rdn;
    ad = w ? m1_addr : m0_addr;
    wd = w ? m1_wdata : m0_wdata;
    nsel = (lat >= TMO) ? TMO + 1 : lat + 1;
    er = '0; eerr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({gnt_id, s_wr_rdn, s_addr, s_wdata} !== {w, wr, ad, wd}) begin
      failures++;
      $display("FAIL issue_cmd got gnt=%0d wr=%0d addr=%h wdata=%h exp gnt=%0d wr=%0d addr=%h wdata=%h",
               gnt_id, s_wr_rdn, s_addr, s_wdata, w, wr, ad, wd);
    end
    for (int k = 0; k < nsel; k++) begin
      checks++;
      if ({s_sel, s_we, busy, m0_ack, m1_ack} !== {1'b1, wr, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL sel_cycle%0d got sel/we/busy/ack0/ack1=%b exp=%b", k,
                 {s_sel, s_we, busy, m0_ack, m1_ack}, {1'b1, wr, 1'b1, 1'b0, 1'b0});
      end
      if (drop_ena && k == 1) ena = 1'b0;
      rv = (fix_rd >= 0) ? REG_W'(fix_rd) : REG_W'($urandom);
      ee = (force_err < 2) ? force_err[0] : 1'($urandom);
      s_rdata = rv; s_err = ee; s_ack = (k == lat);
      if (k == lat) begin er = wr ? '0 : rv; eerr = ee; end
      @(posedge clk); #1;
    end
    s_ack = 1'b0; s_err = 1'b0;
    ack_w = w ? m1_ack : m0_ack;
    ack_o = w ? m0_ack : m1_ack;
    exp_rd[w] = er; exp_er[w] = eerr; model_last = w;
    checks++;
    if ({ack_w, ack_o, s_sel} !== 3'b100) begin
      failures++;
      $display("FAIL resp_ack got win/other/sel=%b exp=100", {ack_w, ack_o, s_sel});
    end
    checks++;
    if ({m0_rdata, m0_err, m1_rdata, m1_err} !== {exp_rd[0], exp_er[0], exp_rd[1], exp_er[1]}) begin
      failures++;
      $display("FAIL resp_data got m0=%h/%0d m1=%h/%0d exp m0=%h/%0d m1=%h/%0d",
               m0_rdata, m0_err, m1_rdata, m1_err, exp_rd[0], exp_er[0], exp_rd[1], exp_er[1]);
    end
    if (w) m1_req = 1'b0; else m0_req = 1'b0;
    ena = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, s_sel, m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err} !==
        {4'b0000, exp_rd[0], exp_rd[1], exp_er[0], exp_er[1]}) begin
      failures++;
      $display("FAIL idle_hold got busy=%0d sel=%0d ack=%0d%0d rd=%h/%h err=%0d%0d",
               busy, s_sel, m0_ack, m1_ack, m0_rdata, m1_rdata, m0_err, m1_err);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #3;
    checks++;
    if ({s_sel, s_we, s_wr_rdn, s_addr, s_wdata, m0_ack, m0_err, m0_rdata,
         m1_ack, m1_err, m1_rdata, busy, gnt_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got nonzero outputs sel=%0d busy=%0d addr=%h exp all 0", s_sel, busy, s_addr);
    end
    apply_reset();
  endtask

  task automatic test_basic_read();
    apply_reset();
    m0_req = 1'b1; m0_wr_rdn = 1'b0; m0_addr = 8'h03; m0_wdata = 8'h00;
    do_txn(0, 1'b0, 0, 8'h5A);
    checks++;
    if (m0_rdata !== 8'h5A) begin
      failures++;
      $display("FAIL basic_read got=%h exp=5a", m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    m0_wr_rdn = 1'b1; m0_addr = 8'h01; m0_wdata = 8'hAA;
    m1_wr_rdn = 1'b0; m1_addr = 8'h81; m1_wdata = 8'h00;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, 2, -1);
      checks++;
      if (gnt_id !== order[i]) begin
        failures++;
        $display("FAIL rr_order%0d got=%0d exp=%0d", i, gnt_id, order[i]);
      end
      m0_req = 1'b1; m1_req = 1'b1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    m1_req = 1'b1; m1_wr_rdn = 1'b0; m1_addr = 8'h42;
    do_txn(TMO + 5, 1'b0, 2, -1);
    checks++;
    if ({m1_rdata, m1_err} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL timeout_resp got rdata=%h err=%0d exp rdata=00 err=1", m1_rdata, m1_err);
    end
  endtask

  task automatic test_ack_err();
    apply_reset();
    m0_req = 1'b1; m0_wr_rdn = 1'b1; m0_addr = 8'h10; m0_wdata = 8'h3C;
    do_txn(6, 1'b0, 1, -1);
    checks++;
    if (m0_err !== 1'b1) begin
      failures++;
      $display("FAIL slave_err got=%0d exp=1", m0_err);
    end
    m0_req = 1'b1; m0_wr_rdn = 1'b0;
    do_txn(TMO, 1'b0, 0, 8'h77);
    checks++;
    if ({m0_err, m0_rdata} !== {1'b0, 8'h77}) begin
      failures++;
      $display("FAIL ack_at_expiry got err=%0d rdata=%h exp err=0 rdata=77", m0_err, m0_rdata);
    end
  endtask

  task automatic test_ena();
    int bad;
    apply_reset();
    ena = 1'b0; m1_req = 1'b1; m1_wr_rdn = 1'b0; m1_addr = 8'h20;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (s_sel !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ena_gate got %0d granted cycles exp 0", bad);
    end
    do_txn(5, 1'b1, 2, -1);
  endtask

  task automatic test_async_reset();
    int acks;
    apply_reset();
    ena = 1'b1; m1_req = 1'b1; m1_wr_rdn = 1'b1; m1_addr = 8'hF0; m1_wdata = 8'h99;
    repeat (4) @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    checks++;
    if ({s_sel, s_we, s_wr_rdn, s_addr, s_wdata, m0_ack, m0_err, m0_rdata,
         m1_ack, m1_err, m1_rdata, busy, gnt_id} !== '0) begin
      failures++;
      $display("FAIL async_reset got sel=%0d busy=%0d addr=%h wdata=%h exp all 0", s_sel, busy, s_addr, s_wdata);
    end
    acks = 0;
    m0_req = 1'b1; m0_wr_rdn = 1'b0; m0_addr = 8'h05;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (m0_ack || m1_ack) acks++;
    end
    rstb = 1'b1;
    model_last = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0; exp_er[0] = 1'b0; exp_er[1] = 1'b0;
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL reset_no_ack got %0d acks exp 0", acks);
    end
    do_txn(2, 1'b0, 2, -1);
    checks++;
    if (gnt_id !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_winner got=%0d exp=0", gnt_id);
    end
    m1_req = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      if (!m0_req) begin
        m0_req = 1'($urandom); m0_wr_rdn = 1'($urandom);
        m0_addr = ADDR_W'($urandom); m0_wdata = REG_W'($urandom);
      end
      if (!m1_req) begin
        m1_req = 1'($urandom); m1_wr_rdn = 1'($urandom);
        m1_addr = ADDR_W'($urandom); m1_wdata = REG_W'($urandom);
      end
      if (!m0_req && !m1_req) begin
        if ($urandom_range(0, 1) == 0) m0_req = 1'b1; else m1_req = 1'b1;
      end
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 3) : $urandom_range(0, 4);
      do_txn(lat, 1'($urandom_range(0, 3) == 0), 2, -1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_timeout();
    test_ack_err();
    test_ena();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
Two-requester round-robin arbiter in front of the register bank's application interface (addr, wdata, wr_rdn, we, rdata, ack, err). Requester 0 is the SPI front-end and requester 1 is the internal/debug master. The block serialises their accesses and drives exactly one register-bank transaction at a time. It adds a bounded-wait timeout so a missing slave ack can never hang a requester.

Parameters:
REG_W, 8, register data width
ADDR_W, 8, register address width (MSB selects config/status space downstream)
TIMEOUT_W, 4, width of wait counter; timeout after 2**TIMEOUT_W wait cycles

Ports:
clk  input  1  clock
rstb  input  1  reset, asynchronous, active-low
ena  input  1  block enable; gates new grants only
m0_req  input  1  requester 0 request, held until m0_ack
m0_wr_rdn  input  1  1=write, 0=read
m0_addr  input  ADDR_W  requester 0 address
m0_wdata  input  REG_W  requester 0 write data
m0_ack  output  1  one-cycle completion pulse
m0_err  output  1  valid with m0_ack
m0_rdata  output  REG_W  valid with m0_ack (reads)
m1_*  same set as m0_* for requester 1
s_sel  output  1  transaction active toward register bank
s_wr_rdn  output  1  latched direction
s_addr  output  ADDR_W  latched address
s_wdata  output  REG_W  latched write data
s_we  output  1  s_sel & s_wr_rdn
s_rdata  input  REG_W  register bank read data
s_ack  input  1  register bank ack
s_err  input  1  register bank error, sampled with s_ack
busy  output  1  state != IDLE
gnt_id  output  1  requester owning current/last transaction

Behaviour:
- Reset: state IDLE; all outputs 0; s_addr/s_wdata/s_wr_rdn 0; last-served pointer = 1, so m0 wins the first contention; wait counter 0.
- FSM IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
- IDLE:
  - If ena=1 and any req: pick winner. A sole requester wins. If both request, the one not last served wins.
  - Latch winner's wr_rdn/addr/wdata into s_* registers and set gnt_id. Go to ISSUE.
  - ena=0: stay in IDLE, grant nothing.
- ISSUE: s_sel=1, s_we=s_wr_rdn.
  - s_ack=1: capture s_rdata (forced 0 on writes) and s_err; go to RESP.
  - Otherwise: clear wait counter; go to WAIT.
- WAIT: s_sel and s_we are held; the counter increments each cycle without ack.
  - s_ack=1: capture as in ISSUE; go to RESP. Ack wins over a simultaneous expiry.
  - Counter == all-ones and no ack: capture rdata=0, err=1; go to RESP.
- RESP: pulse m<gnt_id>_ack=1 for exactly one cycle with captured rdata/err. The other requester's ack stays 0. Update last-served pointer to gnt_id. Go to IDLE.
- m*_rdata/m*_err hold their values until the next RESP for that requester.
- Latency with immediate s_ack: req high in cycle 0, s_sel in cycle 1, ack in cycle 2. Peak throughput is one transaction per 3 cycles.
- Requester contract: hold req and command stable until it samples ack, then deassert at that edge. req seen in IDLE after RESP is a new request. Command changes while not granted are ignored until the latch point.
- ena dropping during ISSUE/WAIT/RESP does not abort; the transaction completes.
- s_ack/s_err outside ISSUE/WAIT are ignored.
- Async reset in any state returns to reset values immediately. No ack is issued for the aborted transaction.

Decomposition:
- Package reg_bank_arb_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP)
  - requester id localparams REQ_SPI=0, REQ_DBG=1
- No sub-module; the round-robin pick and the timeout counter stay inline in the single module.

Test Plan:
- Reset, s_ack tied 1, s_rdata=0x5A; m0 read addr 0x03 -> cycle 1: s_sel=1, s_addr=0x03, s_we=0; cycle 2: m0_ack=1, m0_rdata=0x5A, m0_err=0; m1_ack never 1.
- m0 write 0x01<=0xAA and m1 read 0x81 asserted in the same cycle after reset, both re-requesting continuously -> served order m0,m1,m0,m1. s_we=1 only in m0 ISSUE cycles, with s_wdata=0xAA.
- TIMEOUT_W=4, s_ack held 0, m1 read -> s_sel high for 17 consecutive cycles (1 ISSUE + 16 WAIT), then m1_ack=1, m1_err=1, m1_rdata=0x00; busy returns 0 next cycle.
- s_ack asserted with s_err=1 after 5 WAIT cycles on an m0 write -> m0_ack next cycle with m0_err=1. Repeat with ack in the exact expiry cycle -> err reflects s_err, not timeout.
- ena=0 with m1_req=1 for 10 cycles -> s_sel stays 0. Raise ena -> grant in the next IDLE cycle. Drop ena during WAIT -> transaction still completes with m1_ack.
- Assert rstb=0 during WAIT -> all outputs 0 asynchronously and no ack. After release with both req high -> m0 granted first.
